// File: rtl/mod_dds_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : mod_dds_seq_if
// Description : AXI-Stream-style command channel into the DDS pulse sequencer.
//               The master drives tvalid/tdata and the slave drives tready.
//               TW is the command word width; it is AW+BT+1 by default and
//               AW+BT+5 when MOD_DDS_SEQ_LOOP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface mod_dds_seq_if #(
  parameter int TW = 17
);
  logic          tvalid;
  logic          tready;
  logic [TW-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface
`default_nettype wire

// File: rtl/mod_dds_seq.sv
`default_nettype none
// ============================================================================
// Module      : mod_dds_seq
// Description : DDS pulse sequencer. Pulse commands are buffered in a
//               2**NF-deep FIFO. For each command the 256-bit parameter word
//               is fetched, held on par_dout for the whole pulse, and the time
//               base t = 0..len is generated together with a phase-sync strobe.
//               Optional feature macro: MOD_DDS_SEQ_LOOP_EN (replay each pulse
//               rep+1 times, with rep in tdata[AW+BT+4:AW+BT+1]).
// Ports       : clk, rst        - clock, synchronous active-high reset
//               s_axis          - command stream (slave modport)
//                                 [AW-1:0] addr, [AW+BT-1:AW] len,
//                                 [AW+BT] sync_req
//               mem_en/mem_addr - parameter-memory read request
//               mem_dout        - read data, valid one cycle after mem_en
//               par_dout, ctrl  - held parameter word and its CTRL field
//               sync            - phase-sync strobe on the first sample
//               t_out_valid/t_out - time base
//               busy, done      - activity flag, end-of-pulse strobe
// Revision    : 1.0 - initial release
// ============================================================================
module mod_dds_seq #(
  parameter int BT = 8,
  parameter int AW = 8,
  parameter int NF = 4
) (
  input  logic          clk,
  input  logic          rst,
  mod_dds_seq_if.slave  s_axis,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  input  logic [255:0]  mem_dout,
  output logic [255:0]  par_dout,
  output logic [7:0]    ctrl,
  output logic          sync,
  output logic          t_out_valid,
  output logic [BT-1:0] t_out,
  output logic          busy,
  output logic          done
);
`ifdef MOD_DDS_SEQ_LOOP_EN
  localparam int RW = 4;
`else
  localparam int RW = 0;
`endif
  localparam int          TW      = AW + BT + 1 + RW;
  localparam int          DEPTH   = 2 ** NF;
  localparam logic [NF:0] DEPTH_C = (NF+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LOAD  = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  // Command FIFO
  logic [TW-1:0] fifo_q [DEPTH];
  logic [NF-1:0] wr_ptr_q, rd_ptr_q;
  logic [NF:0]   cnt_q, cnt_d;
  logic          ready_q;
  logic          push_w, pop_w, last_w;
  logic [TW-1:0] head_w;

  // Sequencer
  state_t        state_q;
  logic [BT-1:0] len_q;
  logic          sync_req_q;
  logic [BT-1:0] t_q;
  logic          valid_q, sync_q, done_q, mem_en_q;
  logic [AW-1:0] mem_addr_q;
  logic [255:0]  par_q;
`ifdef MOD_DDS_SEQ_LOOP_EN
  logic [3:0]    rep_q, rep_cnt_q;
`endif

  assign s_axis.tready = ready_q;
  assign push_w        = s_axis.tvalid & ready_q;
  assign head_w        = fifo_q[rd_ptr_q];

  // Last sample of the whole pulse (including all replays when looping).
`ifdef MOD_DDS_SEQ_LOOP_EN
  assign last_w = (state_q == S_RUN) && (t_q == len_q) && (rep_cnt_q == rep_q);
`else
  assign last_w = (state_q == S_RUN) && (t_q == len_q);
`endif

  // Pop either from IDLE or on the last sample, so back-to-back pulses only
  // pay the FETCH and LOAD cycles.
  assign pop_w = (cnt_q != '0) && ((state_q == S_IDLE) || last_w);

  always_comb begin
    cnt_d = cnt_q;
    case ({push_w, pop_w})
      2'b10:   cnt_d = cnt_q + (NF+1)'(1);
      2'b01:   cnt_d = cnt_q - (NF+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push_w) wr_ptr_q <= wr_ptr_q + NF'(1);
      if (pop_w)  rd_ptr_q <= rd_ptr_q + NF'(1);
      cnt_q   <= cnt_d;
      // Registered so tready already reflects the post-update occupancy.
      ready_q <= (cnt_d != DEPTH_C);
    end
  end

  always_ff @(posedge clk) begin
    if (push_w) fifo_q[wr_ptr_q] <= s_axis.tdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      sync_req_q <= 1'b0;
      t_q        <= '0;
      valid_q    <= 1'b0;
      sync_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      par_q      <= '0;
`ifdef MOD_DDS_SEQ_LOOP_EN
      rep_q      <= '0;
      rep_cnt_q  <= '0;
`endif
    end else begin
      mem_en_q <= 1'b0;
      sync_q   <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop_w) begin
            len_q      <= head_w[AW+BT-1:AW];
            sync_req_q <= head_w[AW+BT];
`ifdef MOD_DDS_SEQ_LOOP_EN
            rep_q      <= head_w[AW+BT+4:AW+BT+1];
`endif
            mem_en_q   <= 1'b1;
            mem_addr_q <= head_w[AW-1:0];
            state_q    <= S_FETCH;
          end
        end
        S_FETCH: begin
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          par_q   <= mem_dout;
          t_q     <= '0;
          valid_q <= 1'b1;
          sync_q  <= sync_req_q;
`ifdef MOD_DDS_SEQ_LOOP_EN
          rep_cnt_q <= '0;
`endif
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (last_w) begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            if (pop_w) begin
              len_q      <= head_w[AW+BT-1:AW];
              sync_req_q <= head_w[AW+BT];
`ifdef MOD_DDS_SEQ_LOOP_EN
              rep_q      <= head_w[AW+BT+4:AW+BT+1];
`endif
              mem_en_q   <= 1'b1;
              mem_addr_q <= head_w[AW-1:0];
              state_q    <= S_FETCH;
            end else begin
              state_q <= S_IDLE;
            end
`ifdef MOD_DDS_SEQ_LOOP_EN
          end else if (t_q == len_q) begin
            // Replay without refetch: restart t, keep par_dout, no sync.
            t_q       <= '0;
            rep_cnt_q <= rep_cnt_q + 4'd1;
`endif
          end else begin
            t_q <= t_q + BT'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_en      = mem_en_q;
  assign mem_addr    = mem_addr_q;
  assign par_dout    = par_q;
  assign ctrl        = par_q[231:224];
  assign sync        = sync_q;
  assign t_out_valid = valid_q;
  assign t_out       = t_q;
  assign done        = done_q;
  assign busy        = (state_q != S_IDLE) || (cnt_q != '0);

endmodule
`default_nettype wire

// File: doc/mod_dds_seq.md
Name: mod_dds_seq

Overview:
- Pulse sequencer that drives the DDS modulation datapath from the initiator side.
- Accepts pulse commands on an AXI-Stream-style slave port and buffers them in a command FIFO.
- For each command, fetches the 256-bit parameter word from parameter memory (CTRL/POFF/AMOD/FMOD fields) and holds it stable for the whole pulse.
- Generates the time base t (0..len) with valid, plus a phase-sync strobe, ready to feed the modulated-DDS block's mem_dout/t_in/sync/ctrl inputs.

Parameters:
- BT, 8: width of time base t and of the command length field.
- AW, 8: parameter-memory address width.
- NF, 4: log2 of command FIFO depth (depth 16).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- s_axis_tvalid  in  1  command valid.
- s_axis_tready  out  1  command ready; equals !fifo_full.
- s_axis_tdata  in  AW+BT+1  command: [AW-1:0] addr, [AW+BT-1:AW] len (samples-1), [AW+BT] sync_req.
- mem_en  out  1  parameter-memory read enable.
- mem_addr  out  AW  parameter-memory read address.
- mem_dout  in  256  memory read data, valid exactly 1 cycle after mem_en.
- par_dout  out  256  registered parameter word.
- ctrl  out  8  par_dout[231:224].
- sync  out  1  phase-sync strobe.
- t_out_valid  out  1  time-base valid.
- t_out  out  BT  time base.
- busy  out  1  high when not IDLE or FIFO non-empty.
- done  out  1  one-cycle pulse after the last sample of each pulse.

Behaviour:
- Reset:
  - FIFO emptied; FSM to IDLE.
  - par_dout, t_out, mem_addr all 0.
  - mem_en, sync, t_out_valid, done, busy all 0.
  - s_axis_tready goes 1 the cycle after rst deasserts.
- FIFO:
  - Push on tvalid&tready.
  - Written entry is visible to the FSM the next cycle.
  - Full: tready=0; push and pop in the same cycle are allowed when not full.
  - Pointers wrap modulo 2**NF.
- FSM states:
  - IDLE: if FIFO non-empty, pop into command register, go to FETCH.
  - FETCH: mem_en=1, mem_addr=cmd.addr; go to LOAD.
  - LOAD: par_dout<=mem_dout; t<=0; go to RUN.
  - RUN: t_out_valid=1, t_out=t, t increments each cycle.
    - At t==len: if FIFO non-empty, pop and go to FETCH; else go to IDLE.
    - done=1 the cycle after t==len.
- Timing:
  - Handshake at cycle 0 into an empty FIFO while IDLE gives first t_out_valid at cycle 4.
  - Back-to-back pulses have exactly 2 invalid cycles (FETCH, LOAD).
- par_dout and ctrl change only in LOAD, never while t_out_valid=1.
- sync = cmd.sync_req on the first RUN cycle (t_out=0) only; 0 otherwise.
- len=0 gives a single-sample pulse. len=2**BT-1 gives a full-range count with no t overflow; t must not wrap within a pulse.
- mem_en is high only in FETCH.
- rst mid-pulse: t_out_valid drops the following cycle; queued commands are discarded.

Optional Feature:
- Macro: MOD_DDS_SEQ_LOOP_EN.
- With MOD_DDS_SEQ_LOOP_EN:
  - s_axis_tdata widens by 4 bits: [AW+BT+4:AW+BT+1] rep.
  - Pulse replays rep+1 times back-to-back with no refetch and no gap; t restarts at 0 each replay.
  - sync only on the first replay; done only after the last replay.
- Without it: width AW+BT+1, single play per command.

Test Plan:
- Single command addr=5, len=3, sync_req=1 at cycle 0:
  - mem_en at cycle 2 with mem_addr=5; par_dout=mem word 5 at cycle 4.
  - t_out 0,1,2,3 valid at cycles 4-7; sync only at cycle 4; done at cycle 8.
- Two queued commands (len=1, len=0): valid pattern 1,1,0,0,1; par_dout changes only in the gap.
- Push 17 commands with no drain (NF=4): tready low after 16; the 17th is accepted once the first pop occurs; all 17 pulses emitted in order.
- len=255, BT=8: t_out counts 0..255 with no wrap; done once.
- rst asserted at t_out=2 with 3 commands queued: all outputs 0 the next cycle; no further pulses after rst release.
- LOOP_EN with rep=2, len=1: t_out 0,1,0,1,0,1 contiguous; sync once; mem_en once; done once.
